// File: rtl/hasti_sram_slave.sv
// ---------------------------------------------------------------------------
// hasti_sram_slave
//
// AHB-Lite (HASTI) slave that serves word-addressed on-chip RAM. It sits on
// one output of hasti_slave_mux. It supports byte, half and word writes and
// a configurable number of wait states.
//
// A write commits on the edge that ends its data phase. A read may be
// accepted on that same edge, so the read path forwards the write's enabled
// byte lanes. This keeps a back-to-back write->read to one word coherent.
//
// Handshake: a transfer is accepted in the address phase when
// hsel & hready & htrans[1]. The data phase ends on the first rising edge at
// which hreadyout is 1. hrdata and hresp are valid only in that cycle.
//
// Optional feature macro: HASTI_SRAM_ERR_EN
//   defined   : illegal transfers get a two-cycle ERROR response. Illegal
//               means address bits above the index, hsize > WORD, or a
//               misaligned address.
//   undefined : hresp is tied OKAY and the address wraps modulo DEPTH.
//               hsize > WORD acts as WORD.
//
// Parameters
//   DEPTH        RAM size in 32-bit words (power of 2)
//   WAIT_STATES  wait cycles inserted per OKAY transfer (0..7)
//
// Ports
//   hclk, hreset              clock; asynchronous active-high reset
//   hsel, haddr, hwrite,      address-phase controls
//   hsize, hburst, hprot,     (hburst, hprot and hmastlock are unused)
//   htrans, hmastlock, hready
//   hwdata                    write data (data phase)
//   hrdata, hreadyout, hresp  data-phase response
// ---------------------------------------------------------------------------
module hasti_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic        hmastlock,
    input  logic        hready,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state, state_n;
    logic [2:0]         wait_cnt, wait_cnt_n;

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               illegal;
    logic [IDX_W-1:0]   a_index;
    logic [3:0]         a_lanes;

    logic               d_write;
    logic [IDX_W-1:0]   d_index;
    logic [3:0]         d_lanes;
    logic [31:0]        rd_q;
    logic [31:0]        rd_fwd;

    // These inputs take no part in the behaviour of this slave.
    logic               unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0], haddr[31:IDX_W+2]};

    // ---------------- address phase decode ----------------
    assign accept  = hsel & hready & htrans[1];
    assign a_index = haddr[IDX_W+1:2];

    always_comb begin
        a_lanes = 4'b1111;
        case (hsize)
            3'd0:    a_lanes = 4'b0001 << haddr[1:0];
            3'd1:    a_lanes = haddr[1] ? 4'b1100 : 4'b0011;
            default: a_lanes = 4'b1111;   // WORD; larger sizes act as WORD
        endcase
    end

`ifdef HASTI_SRAM_ERR_EN
    always_comb begin
        illegal = 1'b0;
        if (|haddr[31:IDX_W+2])                  illegal = 1'b1;
        if (hsize > 3'd2)                        illegal = 1'b1;
        if ((hsize == 3'd1) && haddr[0])         illegal = 1'b1;
        if ((hsize == 3'd2) && (|haddr[1:0]))    illegal = 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    // IDLE, DATA and ERR2 all end with hreadyout=1. In those states the
    // next address phase is sampled, so all three share one branch.
    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            ST_WAIT: begin
                if (wait_cnt <= 3'd1) begin
                    state_n    = ST_DATA;
                    wait_cnt_n = 3'd0;
                end else begin
                    wait_cnt_n = wait_cnt - 3'd1;
                end
            end
            ST_ERR1: state_n = ST_ERR2;
            default: begin
                if (accept) begin
                    if (illegal) begin
                        state_n = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_n    = ST_WAIT;
                        wait_cnt_n = 3'(WAIT_STATES);
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    // Response outputs decode straight from the state register.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin
                hreadyout = 1'b0;
`ifdef HASTI_SRAM_ERR_EN
                hresp     = 1'b1;
`endif
            end
            ST_ERR2: begin
`ifdef HASTI_SRAM_ERR_EN
                hresp     = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // ---------------- read path with write forwarding ----------------
    // The pending write commits on this same edge. Its enabled lanes must
    // override the stale RAM word when the read hits the same index.
    always_comb begin
        rd_fwd = mem[a_index];
        if ((state == ST_DATA) && d_write && (d_index == a_index)) begin
            for (int i = 0; i < 4; i++) begin
                if (d_lanes[i]) rd_fwd[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    // Data-phase context. It is captured only while the bus is ready, and
    // it holds through wait and ERR1 cycles.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            d_write <= 1'b0;
            d_index <= '0;
            d_lanes <= 4'b0000;
            rd_q    <= 32'd0;
        end else if (hreadyout) begin
            if (accept && !illegal) begin
                d_write <= hwrite;
                d_index <= a_index;
                d_lanes <= a_lanes;
                rd_q    <= hwrite ? 32'd0 : rd_fwd;
            end else begin
                d_write <= 1'b0;
                rd_q    <= 32'd0;
            end
        end
    end

    assign hrdata = rd_q;

    // ---------------- RAM write port ----------------
    // The RAM is not reset. A reset moves the state out of DATA at once, so
    // an in-flight write never commits.
    always_ff @(posedge hclk) begin
        if ((state == ST_DATA) && d_write) begin
            for (int i = 0; i < 4; i++) begin
                if (d_lanes[i]) mem[d_index][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

endmodule
